// File: rtl/rstack_pkg.sv
// Shared definitions for the return-address stack and the PC-source mux that consumes it.
// Gives the stack, the controller and the PC mux one agreed set of widths and encodings.
package rstack_pkg;

   localparam int RSTACK_ADDR_W = 12;
   localparam int RSTACK_DEPTH  = 8;

   // PC mux select encodings shared by the controller and the PC register.
   typedef enum logic [1:0] {
      PC_SRC_SEQ = 2'b00,
      PC_SRC_JMP = 2'b01,
      PC_SRC_RET = 2'b10
   } pc_src_e;

   // Classified stack operation for one cycle.
   typedef enum logic [1:0] {
      RS_IDLE,
      RS_PUSH,
      RS_POP,
      RS_REPLACE
   } rs_op_e;

   // A simultaneous push+pop on an empty stack degenerates to a plain push.
   function automatic rs_op_e rs_decode(input logic push, input logic pop, input logic empty);
      rs_op_e op;
      if (push && pop && !empty) op = RS_REPLACE;
      else if (push)             op = RS_PUSH;
      else if (pop)              op = RS_POP;
      else                       op = RS_IDLE;
      return op;
   endfunction

endpackage

// File: rtl/rstack_mem.sv
// Register array holding the stacked return addresses.
// Single write port and one combinational read port; every entry clears on reset.
module rstack_mem
   import rstack_pkg::*;
#(
   parameter  int ADDR_W = RSTACK_ADDR_W,
   parameter  int DEPTH  = RSTACK_DEPTH,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [ADDR_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [ADDR_W-1:0] rdata
);

   logic [ADDR_W-1:0] mem [DEPTH];

   // NOTE: the array is reset explicitly because a cleared stack must read back 0s;
   // this forces flops rather than RAM, which is fine at this small depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         // NOTE: non-blocking assignment keeps every flop update ordered to the clock edge.
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack for jsb/ret: tracks pointer, depth and sticky error flags.
// Define RSTACK_CIRCULAR_EN to make a push on a full stack overwrite the oldest entry.
module return_addr_stack
   import rstack_pkg::*;
#(
   parameter  int ADDR_W = RSTACK_ADDR_W,
   parameter  int DEPTH  = RSTACK_DEPTH,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stack_push,
   input  logic              stack_pop,
   input  logic [ADDR_W-1:0] push_addr,
   output logic [ADDR_W-1:0] top_addr,
   output logic              empty,
   output logic              full,
   output logic [PTR_W:0]    depth,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [PTR_W-1:0]  sp, sp_nxt, sp_m1;
   logic [PTR_W:0]    count, count_nxt;
   logic              overflow_nxt, underflow_nxt;
   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   logic [ADDR_W-1:0] mem_rdata;
   rs_op_e            op;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_CNT);
   assign depth = count;
   assign sp_m1 = sp - PTR_ONE;
   assign op    = rs_decode(stack_push, stack_pop, empty);

   rstack_mem #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (push_addr),
      .raddr (sp_m1),
      .rdata (mem_rdata)
   );

   // Popped entries stay in the array, so an empty stack must mask the read.
   assign top_addr = empty ? '0 : mem_rdata;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      mem_we        = 1'b0;
      mem_waddr     = sp;
      sp_nxt        = sp;
      count_nxt     = count;
      overflow_nxt  = overflow;
      underflow_nxt = underflow;
      unique case (op)
         RS_REPLACE: begin
            mem_we    = 1'b1;
            mem_waddr = sp_m1;
         end
         RS_PUSH: begin
            if (!full) begin
               mem_we    = 1'b1;
               sp_nxt    = sp + PTR_ONE;
               count_nxt = count + 1'b1;
            end else begin
               overflow_nxt = 1'b1;
`ifdef RSTACK_CIRCULAR_EN
               // Overwrite the oldest slot; count stays saturated at DEPTH.
               mem_we = 1'b1;
               sp_nxt = sp + PTR_ONE;
`endif
            end
         end
         RS_POP: begin
            if (!empty) begin
               sp_nxt    = sp_m1;
               count_nxt = count - 1'b1;
            end else begin
               underflow_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sp        <= sp_nxt;
         count     <= count_nxt;
         overflow  <= overflow_nxt;
         underflow <= underflow_nxt;
      end
   end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed testbench for return_addr_stack, with a short randomised nesting run against a queue model.
// Expectations follow the build: RSTACK_CIRCULAR_EN selects the overwrite-oldest full behaviour.
module tb_return_addr_stack;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              stack_push = 1'b0;
   logic              stack_pop = 1'b0;
   logic [ADDR_W-1:0] push_addr = '0;
   logic [ADDR_W-1:0] top_addr;
   logic              empty, full, overflow, underflow;
   logic [PTR_W:0]    depth;

   int checks = 0;
   int errors = 0;

   return_addr_stack dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stack_push (stack_push),
      .stack_pop  (stack_pop),
      .push_addr  (push_addr),
      .top_addr   (top_addr),
      .empty      (empty),
      .full       (full),
      .depth      (depth),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   // One clock with the given strobes; outputs are settled when this returns.
   task automatic cyc(input logic p, input logic q, input logic [ADDR_W-1:0] a);
      @(negedge clk);
      stack_push = p;
      stack_pop  = q;
      push_addr  = a;
      @(posedge clk);
      #1;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut();
      repeat (2) cyc(1'b0, 1'b0, '0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
      checks++; if (depth !== 4'd0) begin errors++; $display("FAIL rst_depth got %0d exp 0", depth); end
      checks++; if (top_addr !== 12'h000) begin errors++; $display("FAIL rst_top got %h exp 000", top_addr); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {overflow, underflow}); end
      cyc(1'b1, 1'b0, 12'h111);
      cyc(1'b1, 1'b0, 12'h222);
      cyc(1'b1, 1'b0, 12'h333);
      checks++; if (depth !== 4'd3) begin errors++; $display("FAIL pre_async_depth got %0d exp 3", depth); end
      // Assert reset mid-cycle, well away from any clock edge.
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (depth !== 4'd0) begin errors++; $display("FAIL async_depth got %0d exp 0", depth); end
      checks++; if (top_addr !== 12'h000) begin errors++; $display("FAIL async_top got %h exp 000", top_addr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_empty got %b exp 1", empty); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_push_pop();
      cyc(1'b1, 1'b0, 12'h010);
      cyc(1'b1, 1'b0, 12'h020);
      checks++; if (top_addr !== 12'h020) begin errors++; $display("FAIL push2_top got %h exp 020", top_addr); end
      cyc(1'b1, 1'b0, 12'h030);
      checks++; if (depth !== 4'd3) begin errors++; $display("FAIL push3_depth got %0d exp 3", depth); end
      checks++; if (top_addr !== 12'h030) begin errors++; $display("FAIL push3_top got %h exp 030", top_addr); end
      // The popped value is on top_addr during the request cycle itself.
      @(negedge clk);
      stack_pop = 1'b1;
      #1;
      checks++; if (top_addr !== 12'h030) begin errors++; $display("FAIL pop_comb_top got %h exp 030", top_addr); end
      @(posedge clk);
      #1;
      stack_pop = 1'b0;
      checks++; if (top_addr !== 12'h020) begin errors++; $display("FAIL pop1_top got %h exp 020", top_addr); end
      cyc(1'b0, 1'b1, '0);
      checks++; if (top_addr !== 12'h010) begin errors++; $display("FAIL pop2_top got %h exp 010", top_addr); end
      checks++; if (depth !== 4'd1) begin errors++; $display("FAIL pop2_depth got %0d exp 1", depth); end
   endtask

   task automatic test_underflow();
      cyc(1'b0, 1'b1, '0);
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL drain got empty %b uf %b exp 1 0", empty, underflow); end
      cyc(1'b0, 1'b1, '0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", underflow); end
      checks++; if (depth !== 4'd0) begin errors++; $display("FAIL uf_depth got %0d exp 0", depth); end
      checks++; if (top_addr !== 12'h000) begin errors++; $display("FAIL uf_top got %h exp 000", top_addr); end
      cyc(1'b1, 1'b0, 12'h055);
      checks++; if (top_addr !== 12'h055) begin errors++; $display("FAIL uf_push_top got %h exp 055", top_addr); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow); end
   endtask

   task automatic test_simultaneous();
      reset_dut();
      cyc(1'b1, 1'b0, 12'h010);
      cyc(1'b1, 1'b0, 12'h020);
      cyc(1'b1, 1'b1, 12'h0AA);
      checks++; if (top_addr !== 12'h0AA) begin errors++; $display("FAIL repl_top got %h exp 0aa", top_addr); end
      checks++; if (depth !== 4'd2) begin errors++; $display("FAIL repl_depth got %0d exp 2", depth); end
      cyc(1'b0, 1'b1, '0);
      checks++; if (top_addr !== 12'h010) begin errors++; $display("FAIL repl_below got %h exp 010", top_addr); end
      reset_dut();
      cyc(1'b1, 1'b1, 12'h0AA);
      checks++; if (depth !== 4'd1) begin errors++; $display("FAIL repl_empty_depth got %0d exp 1", depth); end
      checks++; if (top_addr !== 12'h0AA) begin errors++; $display("FAIL repl_empty_top got %h exp 0aa", top_addr); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL repl_empty_uf got %b exp 0", underflow); end
   endtask

   task automatic test_full();
      logic [ADDR_W-1:0] exp_top;
      reset_dut();
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, ADDR_W'(i));
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
      checks++; if (top_addr !== 12'h008) begin errors++; $display("FAIL full_top got %h exp 008", top_addr); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_of got %b exp 0", overflow); end
      cyc(1'b1, 1'b0, 12'h009);
`ifdef RSTACK_CIRCULAR_EN
      exp_top = 12'h009;
`else
      exp_top = 12'h008;
`endif
      checks++; if (top_addr !== exp_top) begin errors++; $display("FAIL of_top got %h exp %h", top_addr, exp_top); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL of_flag got %b exp 1", overflow); end
      checks++; if (depth !== 4'd8) begin errors++; $display("FAIL of_depth got %0d exp 8", depth); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (top_addr !== exp_top) begin errors++; $display("FAIL of_pop%0d got %h exp %h", i, top_addr, exp_top); end
         cyc(1'b0, 1'b1, '0);
         exp_top = exp_top - 12'h001;
      end
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL of_drain got empty %b uf %b exp 1 0", empty, underflow); end
   endtask

   task automatic test_random_nesting();
      logic [ADDR_W-1:0] model_q[$];
      logic [ADDR_W-1:0] exp_top, a;
      int                sel;
      reset_dut();
      for (int c = 0; c < 1000; c++) begin
         a   = ADDR_W'($urandom);
         sel = int'($urandom_range(0, 2));
         if (model_q.size() == 0) sel = 0;
         else if (model_q.size() == 4 && sel == 0) sel = 1;
         if (sel == 0) begin
            cyc(1'b1, 1'b0, a);
            model_q.push_back(a);
         end else if (sel == 1) begin
            cyc(1'b0, 1'b1, '0);
            void'(model_q.pop_back());
         end else begin
            cyc(1'b0, 1'b0, a);
         end
         exp_top = (model_q.size() == 0) ? '0 : model_q[$];
         checks++;
         if (top_addr !== exp_top || depth !== (PTR_W + 1)'(model_q.size()) || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_c%0d got top %h depth %0d of %b uf %b exp top %h depth %0d flags 0",
                     c, top_addr, depth, overflow, underflow, exp_top, model_q.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_underflow();
      test_simultaneous();
      test_full();
      test_random_nesting();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
